pll_supervisor: RTL and testbench

Sequences PLL start-up and resets for the clock domains the PLL feeds. Drives the PLL's reset input and watches its `locked` output, retrying on lock timeout. Once lock is stable it releases per-domain resets in a fixed order, and it re-sequences on loss of lock. Runs on the free-running board reference clock (25 MHz), never on a PLL output.

---
 rtl/pll_supervisor.sv | 186 ++++++++++++++++++
 tb/tb_pll_supervisor.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - PLL start-up, lock supervision and staggered domain reset release.
// Optional macro PLL_SUPERVISOR_DROP_FILTER_EN: require 4 consecutive low lock cycles before relock.
module pll_supervisor #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 250000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned NUM_DOMAINS    = 3,
   parameter int unsigned RELEASE_GAP    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   force_relock,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   ready,
   output logic                   fault,
   output logic [3:0]             retry_count
);

   typedef enum logic [2:0] {
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   localparam logic [31:0] C_RST_LAST     = 32'(PLL_RST_CYCLES - 1);
   localparam logic [31:0] C_TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
   localparam logic [31:0] C_STABLE_LAST  = 32'(STABLE_CYCLES - 1);
   localparam logic [31:0] C_RELEASE_LAST = 32'(NUM_DOMAINS * RELEASE_GAP - 1);
   localparam logic [3:0]  C_MAX_RETRIES  = 4'(MAX_RETRIES);

   state_t                 r_state;
   logic [31:0]            r_cnt;
   logic                   r_sync1;
   logic                   r_lock_s;
   logic                   r_pll_rst;
   logic [NUM_DOMAINS-1:0] r_rst_out_n;
   logic                   r_ready;
   logic                   r_fault;
   logic [3:0]             r_retry;
   logic [NUM_DOMAINS-1:0] w_rel_mask;
   logic                   w_drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_sync1  <= pll_locked;
         r_lock_s <= r_sync1;
      end
   end

`ifdef PLL_SUPERVISOR_DROP_FILTER_EN
   // Counts consecutive low lock_s cycles while domains are (being) released.
   logic [1:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= 2'd0;
      end else if ((r_state == S_RELEASE || r_state == S_RUN) && !r_lock_s) begin
         r_drop_cnt <= r_drop_cnt + 2'd1;
      end else begin
         r_drop_cnt <= 2'd0;
      end
   end

   assign w_drop = !r_lock_s && (r_drop_cnt == 2'd3);
`else
   assign w_drop = !r_lock_s;
`endif

   // Domains whose release point has been reached on the coming edge.
   always_comb begin
      w_rel_mask = '0;
      for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
         if (r_cnt + 32'd1 >= 32'(i * RELEASE_GAP)) begin
            w_rel_mask[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_PLL_RESET;
         r_cnt       <= '0;
         r_pll_rst   <= 1'b1;
         r_rst_out_n <= '0;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
         r_retry     <= '0;
      end else begin
         case (r_state)
            S_PLL_RESET: begin
               if (r_cnt == C_RST_LAST) begin
                  r_state   <= S_WAIT_LOCK;
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_WAIT_LOCK: begin
               if (r_lock_s) begin
                  r_state <= S_STABILIZE;
                  r_cnt   <= '0;
               end else if (r_cnt == C_TIMEOUT_LAST) begin
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b1;
                  if (r_retry == C_MAX_RETRIES) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= S_PLL_RESET;
                     r_retry <= r_retry + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_STABILIZE: begin
               if (!r_lock_s) begin
                  r_state <= S_WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STABLE_LAST) begin
                  r_state     <= S_RELEASE;
                  r_cnt       <= '0;
                  r_rst_out_n <= NUM_DOMAINS'(1);
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_RELEASE: begin
               if (w_drop) begin
                  r_state     <= S_PLL_RESET;
                  r_cnt       <= '0;
                  r_pll_rst   <= 1'b1;
                  r_rst_out_n <= '0;
                  r_ready     <= 1'b0;
                  r_retry     <= '0;
               end else if (r_cnt == C_RELEASE_LAST) begin
                  r_state     <= S_RUN;
                  r_cnt       <= '0;
                  r_rst_out_n <= '1;
                  r_ready     <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + 32'd1;
                  r_rst_out_n <= w_rel_mask;
               end
            end
            S_RUN: begin
               if (w_drop || force_relock) begin
                  r_state     <= S_PLL_RESET;
                  r_cnt       <= '0;
                  r_pll_rst   <= 1'b1;
                  r_rst_out_n <= '0;
                  r_ready     <= 1'b0;
                  r_retry     <= '0;
               end
            end
            S_FAULT: begin
               r_pll_rst   <= 1'b1;
               r_rst_out_n <= '0;
               r_ready     <= 1'b0;
               r_fault     <= 1'b1;
            end
            default: begin
               r_state <= S_PLL_RESET;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign pll_rst     = r_pll_rst;
   assign rst_out_n   = r_rst_out_n;
   assign ready       = r_ready;
   assign fault       = r_fault;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb/tb_pll_supervisor.sv - directed bench for pll_supervisor with a timeline-based reference model.
module tb_pll_supervisor;

   localparam int P_RST  = 4;
   localparam int P_TO   = 64;
   localparam int P_STAB = 16;
   localparam int P_MAXR = 2;
   localparam int P_ND   = 3;
   localparam int P_GAP  = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pll_locked;
   logic            force_relock;
   logic            pll_rst;
   logic [P_ND-1:0] rst_out_n;
   logic            ready;
   logic            fault;
   logic [3:0]      retry_count;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   pll_supervisor #(
      .PLL_RST_CYCLES (P_RST),
      .LOCK_TIMEOUT   (P_TO),
      .STABLE_CYCLES  (P_STAB),
      .MAX_RETRIES    (P_MAXR),
      .NUM_DOMAINS    (P_ND),
      .RELEASE_GAP    (P_GAP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .force_relock (force_relock),
      .pll_rst      (pll_rst),
      .rst_out_n    (rst_out_n),
      .ready        (ready),
      .fault        (fault),
      .retry_count  (retry_count)
   );

   always #5 clk = ~clk;

   // Reference model: phase plus the cycle it was entered; outputs follow from elapsed time.
   typedef enum {M_RST, M_WAIT, M_STAB, M_REL, M_RUN, M_FAULT} mph_t;
   mph_t m_ph;
   int   m_cyc = 0;
   int   m_t;
   int   m_retry;
   int   m_low;
   logic m_s1, m_s2;

   task automatic m_reset();
      m_ph    = M_RST;
      m_t     = m_cyc;
      m_retry = 0;
      m_low   = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
   endtask

   task automatic m_go(input mph_t p);
      m_ph = p;
      m_t  = m_cyc;
   endtask

   task automatic m_step();
      logic ls;
      logic drop;
      int   e;
      ls    = m_s2;
      m_s2  = m_s1;
      m_s1  = pll_locked;
      m_cyc = m_cyc + 1;
      e     = m_cyc - m_t;
      if ((m_ph == M_REL || m_ph == M_RUN) && !ls) m_low = m_low + 1;
      else m_low = 0;
`ifdef PLL_SUPERVISOR_DROP_FILTER_EN
      drop = (m_low >= 4);
`else
      drop = !ls;
`endif
      case (m_ph)
         M_RST:  if (e == P_RST) m_go(M_WAIT);
         M_WAIT: begin
            if (ls) m_go(M_STAB);
            else if (e == P_TO) begin
               if (m_retry == P_MAXR) m_go(M_FAULT);
               else begin
                  m_retry = m_retry + 1;
                  m_go(M_RST);
               end
            end
         end
         M_STAB: begin
            if (!ls) m_go(M_WAIT);
            else if (e == P_STAB) m_go(M_REL);
         end
         M_REL: begin
            if (drop) begin
               m_retry = 0;
               m_go(M_RST);
            end else if (e == P_ND * P_GAP) m_go(M_RUN);
         end
         M_RUN: begin
            if (drop || force_relock) begin
               m_retry = 0;
               m_go(M_RST);
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      logic [P_ND-1:0] e_rst_out;
      forever begin
         @(negedge clk);
         for (int i = 0; i < P_ND; i++) begin
            e_rst_out[i] = (m_ph == M_RUN) || (m_ph == M_REL && (m_cyc - m_t) >= i * P_GAP);
         end
         n_cmp++;
         if (pll_rst !== (m_ph == M_RST || m_ph == M_FAULT) || rst_out_n !== e_rst_out ||
             ready !== (m_ph == M_RUN) || fault !== (m_ph == M_FAULT) ||
             retry_count !== 4'(m_retry)) begin
            n_err++;
            $display("FAIL model t=%0t: got pll_rst=%b rst_out_n=%b ready=%b fault=%b retry=%0d want %b %b %b %b %0d",
                     $time, pll_rst, rst_out_n, ready, fault, retry_count,
                     (m_ph == M_RST || m_ph == M_FAULT), e_rst_out, (m_ph == M_RUN),
                     (m_ph == M_FAULT), m_retry);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig_of(input int sel);
      case (sel)
         0:       return pll_rst;
         1:       return rst_out_n[0];
         2:       return rst_out_n[1];
         3:       return rst_out_n[2];
         4:       return ready;
         default: return fault;
      endcase
   endfunction

   // Edges until signal sel equals val (1-based), -1 if the budget expires.
   task automatic edges_until(input int sel, input logic val, input int budget, output int k_out);
      k_out = -1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk);
         #1;
         if (sig_of(sel) === val) begin
            k_out = k;
            break;
         end
      end
   endtask

   task automatic tick(input int cnt);
      repeat (cnt) @(posedge clk);
      #1;
   endtask

   // Drop pll_locked for dlen cycles; report edges until ready falls.
   task automatic drop_lock(input int dlen, input int budget, output int k_out);
      k_out = -1;
      pll_locked = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk);
         #1;
         if (k == dlen) pll_locked = 1'b1;
         if (ready === 1'b0 && k_out < 0) begin
            k_out = k;
            if (k >= dlen) break;
         end
      end
      pll_locked = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      force_relock = 1'b0;
      tick(3);
      check("reset_pll_rst", int'(pll_rst), 1);
      check("reset_rst_out_n", int'(rst_out_n), 0);
      check("reset_ready", int'(ready), 0);
      check("reset_fault", int'(fault), 0);
      check("reset_retry", int'(retry_count), 0);
      rst_n = 1'b1;

      // Nominal start
      edges_until(0, 1'b0, 20, n);
      check("nom_pll_rst_len", n, 4);
      tick(10);
      pll_locked = 1'b1;
      edges_until(1, 1'b1, 40, n);
      check("nom_rst0", n, 19);
      edges_until(2, 1'b1, 20, n);
      check("nom_rst1", n + 19, 27);
      edges_until(3, 1'b1, 20, n);
      check("nom_rst2", n + 27, 35);
      edges_until(4, 1'b1, 20, n);
      check("nom_ready", n + 35, 43);
      check("nom_fault", int'(fault), 0);
      check("nom_retry", int'(retry_count), 0);

      // Lock loss in RUN
      tick(5);
`ifdef PLL_SUPERVISOR_DROP_FILTER_EN
      drop_lock(1, 12, n);
      check("filt_glitch_ignored", n, -1);
      drop_lock(5, 20, n);
      check("filt_drop_latency", n, 6);
`else
      drop_lock(1, 20, n);
      check("loss_latency", n, 3);
`endif
      check("loss_rst_out_n", int'(rst_out_n), 0);
      check("loss_pll_rst", int'(pll_rst), 1);
      check("loss_retry", int'(retry_count), 0);
      edges_until(0, 1'b0, 20, n);
      check("loss_pll_rst_len", n, 4);
      edges_until(4, 1'b1, 100, n);
      check("loss_ready_again", n, 41);

      // force_relock in RUN
      tick(3);
      force_relock = 1'b1;
      tick(1);
      force_relock = 1'b0;
      check("force_ready", int'(ready), 0);
      check("force_pll_rst", int'(pll_rst), 1);
      check("force_rst_out_n", int'(rst_out_n), 0);
      edges_until(0, 1'b0, 20, n);
      check("force_pll_rst_len", n, 4);
      edges_until(4, 1'b1, 100, n);
      check("force_ready_again", n, 41);

      // Lose lock permanently, pulse force_relock in WAIT_LOCK, then run out of retries
      tick(2);
      pll_locked = 1'b0;
      edges_until(4, 1'b0, 20, n);
`ifdef PLL_SUPERVISOR_DROP_FILTER_EN
      check("perm_loss_latency", n, 6);
`else
      check("perm_loss_latency", n, 3);
`endif
      edges_until(0, 1'b0, 20, n);
      check("perm_pll_rst_len", n, 4);
      force_relock = 1'b1;
      tick(1);
      force_relock = 1'b0;
      check("wait_force_ignored", int'(pll_rst), 0);
      edges_until(0, 1'b1, 100, n);
      check("timeout1", n, 63);
      check("timeout1_retry", int'(retry_count), 1);
      edges_until(0, 1'b0, 20, n);
      check("retry1_pll_rst_len", n, 4);
      edges_until(0, 1'b1, 100, n);
      check("timeout2", n, 64);
      check("timeout2_retry", int'(retry_count), 2);
      edges_until(0, 1'b0, 20, n);
      check("retry2_pll_rst_len", n, 4);
      edges_until(5, 1'b1, 100, n);
      check("fault_time", n, 64);
      check("fault_retry", int'(retry_count), 2);
      check("fault_pll_rst", int'(pll_rst), 1);
      check("fault_rst_out_n", int'(rst_out_n), 0);
      tick(10);
      check("fault_sticky", int'(fault), 1);
      check("fault_ready", int'(ready), 0);

      // rst_n clears fault; chatter during STABILIZE
      rst_n = 1'b0;
      #1;
      check("rst_clears_fault", int'(fault), 0);
      check("rst_clears_retry", int'(retry_count), 0);
      tick(2);
      rst_n = 1'b1;
      edges_until(0, 1'b0, 20, n);
      check("chat_pll_rst_len", n, 4);
      tick(2);
      pll_locked = 1'b1;
      tick(10);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      edges_until(1, 1'b1, 60, n);
      check("chat_rst0_from_second_rise", n, 19);

      // Reset in the middle of RELEASE
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrel_pll_rst", int'(pll_rst), 1);
      check("midrel_rst_out_n", int'(rst_out_n), 0);
      check("midrel_ready", int'(ready), 0);
      tick(2);
      rst_n = 1'b1;
      edges_until(0, 1'b0, 20, n);
      check("midrel_pll_rst_len", n, 4);
      edges_until(1, 1'b1, 40, n);
      check("midrel_rst0", n, 17);
      edges_until(2, 1'b1, 20, n);
      check("midrel_rst1", n, 8);
      edges_until(3, 1'b1, 20, n);
      check("midrel_rst2", n, 8);
      edges_until(4, 1'b1, 20, n);
      check("midrel_ready", n, 8);
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
